// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit_pkg
//  Brief    : SPECIAL funct encodings and FSM state type for the mul/div unit
//  Revision : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    // SPECIAL funct codes handled by (or reading from) the mul/div unit
    localparam logic [5:0] FUN_MFHI  = 6'b010000;
    localparam logic [5:0] FUN_MTHI  = 6'b010001;
    localparam logic [5:0] FUN_MFLO  = 6'b010010;
    localparam logic [5:0] FUN_MTLO  = 6'b010011;
    localparam logic [5:0] FUN_MULT  = 6'b011000;
    localparam logic [5:0] FUN_MULTU = 6'b011001;
    localparam logic [5:0] FUN_DIV   = 6'b011010;
    localparam logic [5:0] FUN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // True for the four ops that occupy the iterative datapath
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FUN_MULT) || (f == FUN_MULTU) ||
               (f == FUN_DIV)  || (f == FUN_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module   : iter_divider
//  Brief    : Unsigned restoring divider, one quotient bit per step
//  Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // The quotient register starts holding the dividend; its MSB is shifted
    // into the partial remainder each step while quotient bits enter the LSB.
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dsr};

    // Load operands, then one trial subtraction per step (restore on borrow)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
        end else if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dsr <= divisor;
        end else if (step) begin
            if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Brief    : Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and
//             MTHI/MTLO writes; busy stalls dependent instructions upstream
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH       = 32,   // even, >= 4
    parameter int MUL_RADIX_B = 1     // 1, 2 or 4; must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_MUL_LAST = c_CW'(WIDTH / MUL_RADIX_B - 1);
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    md_state_t r_state, w_state_nxt;

    logic             w_accept;
    logic             w_commit;
    logic             w_idle_req;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_signed;
    logic             w_is_div;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_raw_a;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH+MUL_RADIX_B-1:0] w_pp;
    logic [WIDTH+MUL_RADIX_B-1:0] w_upper;
    logic [2*WIDTH-1:0]           w_acc_step;
    logic [WIDTH-1:0]             w_quo;
    logic [WIDTH-1:0]             w_rem;
    logic [2*WIDTH-1:0]           w_prod;
    logic [WIDTH-1:0]             w_res_hi;
    logic [WIDTH-1:0]             w_res_lo;

    // ------------------------------------------------------------------
    // Request decode; abort masks every kind of request, including MTHI/MTLO
    // ------------------------------------------------------------------
    assign w_idle_req = (r_state == MD_IDLE) && start && !abort;
    assign w_mthi     = w_idle_req && (funct == FUN_MTHI);
    assign w_mtlo     = w_idle_req && (funct == FUN_MTLO);
    assign w_signed   = (funct == FUN_MULT) || (funct == FUN_DIV);
    assign w_is_div   = (funct == FUN_DIV)  || (funct == FUN_DIVU);
    assign w_mag_a    = (w_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_mag_b    = (w_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, accept and commit strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_idle_req && is_muldiv(funct)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MD_CALC;
                end
            end
            MD_CALC: begin
                if (abort) begin
                    w_state_nxt = MD_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = MD_FIX;
                end
            end
            MD_FIX: begin
                w_state_nxt = MD_IDLE;
                w_commit    = !abort;
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier: the low half of the accumulator holds the
    // remaining multiplier bits, consumed MUL_RADIX_B at a time from the LSB.
    // ------------------------------------------------------------------
    assign w_pp    = {{MUL_RADIX_B{1'b0}}, r_mcand} *
                     {{WIDTH{1'b0}}, r_acc[MUL_RADIX_B-1:0]};
    assign w_upper = {{MUL_RADIX_B{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;

    generate
        if (MUL_RADIX_B == WIDTH) begin : g_step_full
            assign w_acc_step = w_upper;
        end else begin : g_step_part
            assign w_acc_step = {w_upper, r_acc[WIDTH-1:MUL_RADIX_B]};
        end
    endgenerate

    // Operand capture on accept, then iterate while in CALC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_raw_a   <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_is_div  <= w_is_div;
            r_neg_res <= w_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            r_neg_rem <= w_signed && rs_val[WIDTH-1];
            r_dz      <= (rt_val == '0);
            r_raw_a   <= rs_val;
            r_mcand   <= w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt     <= w_is_div ? c_DIV_LAST : c_MUL_LAST;
        end else if (r_state == MD_CALC) begin
            r_cnt <= r_cnt - c_ONE;
            if (!r_is_div) begin
                r_acc <= w_acc_step;
            end
        end
    end

    iter_divider #(
        .WIDTH     (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept && w_is_div),
        .step      ((r_state == MD_CALC) && r_is_div),
        .dividend  (w_mag_a),
        .divisor   (w_mag_b),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Sign fix-up and divide-by-zero result selection used in FIX
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_res_hi = r_raw_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_neg_rem ? -w_rem : w_rem;
                w_res_lo = r_neg_res ? -w_quo : w_quo;
            end
        end
    end

    // HI/LO registers: result commit from FIX, or direct moves while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (w_mthi) begin
                r_hi <= rs_val;
            end
            if (w_mtlo) begin
                r_lo <= rs_val;
            end
        end
    end

    // done pulses the cycle after HI/LO take a mul/div result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
        end
    end

    assign busy = (r_state != MD_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Brief    : Directed self-checking bench for mul_div_unit (radix 1 and 4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MTHI  = 6'b010001;
    localparam logic [5:0] c_F_MTLO  = 6'b010011;
    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        s4_start, s4_abort;
    logic [5:0]  s4_funct;
    logic [31:0] s4_rs, s4_rt;
    logic        s4_busy, s4_done;
    logic [31:0] s4_hi, s4_lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .MUL_RADIX_B(1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .abort(abort),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(32), .MUL_RADIX_B(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .funct(s4_funct),
        .rs_val(s4_rs), .rt_val(s4_rt), .abort(s4_abort),
        .busy(s4_busy), .done(s4_done), .hi(s4_hi), .lo(s4_lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns #1 after that edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct  = f;
        rs_val = a;
        rt_val = b;
        @(posedge clk); #1;
        start  = 1'b0;
        funct  = 6'd0;
    endtask

    // Count busy cycles until idle (bounded)
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(f, a, b);
        wait_idle(cyc);
        check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk); #1;
        check({tag, " done_cleared"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        rst = 1'b1; start = 1'b0; abort = 1'b0; funct = 6'd0;
        rs_val = '0; rt_val = '0;
        s4_start = 1'b0; s4_abort = 1'b0; s4_funct = 6'd0; s4_rs = '0; s4_rt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        run_op("multu_max", c_F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg3x7", c_F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_neg7_2", c_F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2", c_F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("divu_7_0", c_F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_op("div_neg7_0", c_F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf", c_F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("divu_100_7", c_F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Radix-4 instance: same signed product, shorter latency
        s4_start = 1'b1; s4_funct = c_F_MULT; s4_rs = 32'hFFFFFFFD; s4_rt = 32'd7;
        @(posedge clk); #1;
        s4_start = 1'b0; s4_funct = 6'd0;
        cyc = 0;
        while (s4_busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("r4 busy_cycles", 64'(cyc), 64'd9);
        check("r4 done", 64'(s4_done), 64'd1);
        check("r4 hi", 64'(s4_hi), 64'hFFFFFFFF);
        check("r4 lo", 64'(s4_lo), 64'hFFFFFFEB);

        // MTHI / MTLO: immediate write, no busy, no done
        issue(c_F_MTHI, 32'h1234, 32'd0);
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        issue(c_F_MTLO, 32'h5678, 32'd0);
        check("mtlo lo", 64'(lo), 64'h5678);

        // Abort at busy cycle 10 of MULTU 3*5
        issue(c_F_MULTU, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        check("abort busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy_after", 64'(busy), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort no_done", 64'(pulses), 64'd0);
        check("abort hi", 64'(hi), 64'h1234);
        check("abort lo", 64'(lo), 64'h5678);

        // MTLO while busy is ignored
        issue(c_F_DIVU, 32'd100, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        issue(c_F_MTLO, 32'hDEAD, 32'd0);
        check("busy_mtlo lo", 64'(lo), 64'h5678);
        wait_idle(cyc);
        check("busy_mtlo done", 64'(done), 64'd1);
        check("busy_mtlo result_lo", 64'(lo), 64'd14);
        check("busy_mtlo result_hi", 64'(hi), 64'd2);

        // New start in the done cycle is accepted
        issue(c_F_MULTU, 32'd3, 32'd5);
        wait_idle(cyc);
        check("b2b first_lo", 64'(lo), 64'd15);
        check("b2b done", 64'(done), 64'd1);
        issue(c_F_MULTU, 32'd6, 32'd7);
        check("b2b accepted", 64'(busy), 64'd1);
        wait_idle(cyc);
        check("b2b busy_cycles", 64'(cyc), 64'd33);
        check("b2b second_lo", 64'(lo), 64'd42);
        check("b2b second_hi", 64'(hi), 64'd0);

        // Reset at busy cycle 5 of a DIV
        issue(c_F_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid hi", 64'(hi), 64'd0);
        check("rst_mid lo", 64'(lo), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("rst_mid no_done", 64'(pulses), 64'd0);

        // Abort with start in the same cycle: nothing accepted
        abort = 1'b1;
        issue(c_F_MULTU, 32'd3, 32'd5);
        check("abort_start busy", 64'(busy), 64'd0);
        issue(c_F_MTHI, 32'hAAAA, 32'd0);
        abort = 1'b0;
        check("abort_mthi hi", 64'(hi), 64'd0);

        // Unrecognised funct is ignored
        issue(c_F_MFHI, 32'h5555, 32'h6666);
        check("unknown busy", 64'(busy), 64'd0);
        check("unknown hi", 64'(hi), 64'd0);
        check("unknown lo", 64'(lo), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
